johnson_phase_tracker: RTL and testbench
========================================

# johnson_phase_tracker

Downstream consumer of the 8-bit Johnson counter. It samples the counter's code word and decodes it to a binary phase index. It checks that successive codes are legal and step by exactly +1 modulo 2·(size+1), and acquires and holds a lock. It also counts full revolutions and reports code and sequence errors to the scan/test logic.

## Interface
Parameters:
- size, 7: Johnson word is jc_in[0:size], so N = size+1 = 8 bits and there are 2N = 16 legal states.
- LOCK_N, 4: number of consecutive in-sequence legal samples required to assert locked. Valid range is 2..15.
- CNT_W, 8: width of the revolution counter.
- Local PW = $clog2(2N), which is 4 at the defaults.

Ports:
- clk, input, 1: single clock; all state updates on the posedge.
- r, input, 1: reset. Synchronous, active-high, sampled on the posedge of clk.
- jc_in, input, [0:size]: Johnson code word. Bit 0 is the shift-in end, fed with ~jc[size].
- in_valid, input, 1: jc_in is sampled only when in_valid=1.
- clr_err, input, 1: clears err_sticky.
- phase, output, [PW-1:0]: decoded phase of the last legal sample.
- locked, output, 1: tracker is in LOCKED.
- rev_pulse, output, 1: one-cycle pulse on each wrap from phase 2N-1 to 0 while locked.
- rev_cnt, output, [CNT_W-1:0]: revolution count.
- err_code, output, 1: one-cycle pulse when an illegal code is sampled.
- err_seq, output, 1: one-cycle pulse when a legal but out-of-sequence code is sampled while locked.
- err_sticky, output, 1: latched OR of err_code and err_seq.

## Operation
- Legal code: at most one bit position i (0..size-1) with jc_in[i] != jc_in[i+1]. Every other pattern is illegal.
- Decode, with ones = popcount(jc_in):
  - jc_in[0]=1: phase = ones (1..N).
  - jc_in[0]=0 and ones=0: phase = 0.
  - otherwise: phase = 2N - ones.
  - Example codes in [0:7] order: 00000000→0, 10000000→1, 11111111→8, 01111111→9, 00000001→15.
- Expected next phase = (prev + 1) mod 2N, wrapping 15→0.
- FSM states: SEARCH, ACQ, LOCKED. Only cycles with in_valid=1 are evaluated; in_valid=0 holds all state, and pulses are 0.
  - SEARCH:
    - Legal sample: store phase, match_cnt=1, go to ACQ.
    - Illegal sample: pulse err_code, stay in SEARCH.
  - ACQ:
    - Legal and in-sequence: match_cnt+1. When match_cnt reaches LOCK_N, go to LOCKED.
    - Legal but out of sequence: restart with match_cnt=1 and the new phase. No error is flagged.
    - Illegal: pulse err_code, go to SEARCH.
  - LOCKED:
    - In-sequence: update phase.
    - Wrap 2N-1→0: pulse rev_pulse, rev_cnt+1. rev_cnt wraps modulo 2^CNT_W with no saturation.
    - Illegal: pulse err_code, go to SEARCH.
    - Legal but not prev+1 (including a repeat of the same phase): pulse err_seq, go to SEARCH.
- Phase on errors: phase updates on every legal sample. It holds on an illegal sample.
- err_sticky:
  - Set by any err_code or err_seq.
  - Cleared by clr_err.
  - If a set and clr_err happen in the same cycle, set wins.
  - Not cleared on loss of lock.
- rev_cnt is cleared only by r; it holds across lock loss.

## Timing
- All outputs are registered. For a sample at edge t, the response appears after edge t, with 1-cycle latency.
- locked rises after the LOCK_N-th consecutive in-sequence sample and falls after the first erroring sample.
- rev_pulse, err_code and err_seq are high for exactly one cycle per event.
- Reset: r=1 at an edge forces the following after that edge, overriding all other inputs including in_valid:
  - phase=0, locked=0, rev_pulse=0, rev_cnt=0, err_code=0, err_seq=0, err_sticky=0.
  - FSM=SEARCH, match_cnt=0.
- Reset mid-lock: locked drops the next cycle. Re-acquisition needs a fresh LOCK_N samples.

## Test plan
- Acquire lock: release r, drive a live Johnson counter from 00000000 with in_valid=1.
  - Sample phases 0,1,2,3 → locked=1 after the 4th sample, phase=3, no errors.
- Revolution count:
  - Continue 16 more samples after lock → rev_pulse is a single cycle on 15→0, rev_cnt=1.
  - Continue 256 revolutions with CNT_W=8 → rev_cnt wraps to 0.
- Illegal code: while locked at phase 5, inject 10100000.
  - → err_code pulse, err_sticky=1, locked=0, phase stays 5.
  - Then 4 clean samples → relock.
- Sequence skip: while locked, feed phase 5 then 7 (11111110 is phase 7).
  - → err_seq pulse, locked=0, phase=7.
  - A repeat of the same phase also → err_seq.
- Gaps: while locked, interleave in_valid=0 cycles carrying garbage jc_in.
  - → no error, locked stays 1, phase holds.
- Reset and clear precedence:
  - r=1 for one cycle while locked with rev_cnt=3 → all outputs 0 the next cycle.
  - clr_err=1 in the same cycle as an illegal sample → err_sticky remains 1.
  - clr_err alone → err_sticky=0.

Source files
------------

// File: rtl/johnson_phase_tracker_if.sv
// Sample/status bundle between a Johnson counter source and its phase tracker.
// The master drives the code word and controls; the slave returns decoded status.
interface johnson_phase_tracker_if #(
    parameter int size  = 7,
    parameter int CNT_W = 8
);
    localparam int PW = $clog2(2 * (size + 1));

    logic [0:size]      jc_in;
    logic               in_valid;
    logic               clr_err;
    logic [PW-1:0]      phase;
    logic               locked;
    logic               rev_pulse;
    logic [CNT_W-1:0]   rev_cnt;
    logic               err_code;
    logic               err_seq;
    logic               err_sticky;

    modport master (
        output jc_in, in_valid, clr_err,
        input  phase, locked, rev_pulse, rev_cnt,
        input  err_code, err_seq, err_sticky
    );

    modport slave (
        input  jc_in, in_valid, clr_err,
        output phase, locked, rev_pulse, rev_cnt,
        output err_code, err_seq, err_sticky
    );
endinterface

// File: rtl/johnson_phase_tracker.sv
// Decodes a sampled Johnson code word to a phase index, tracks lock on a
// +1 stepping sequence, counts revolutions and flags code/sequence errors.
module johnson_phase_tracker #(
    parameter int size   = 7,
    parameter int LOCK_N = 4,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic r,
    johnson_phase_tracker_if.slave bus
);
    localparam int N  = size + 1;
    localparam int M  = 2 * N;
    localparam int PW = $clog2(M);
    localparam int OW = $clog2(N + 1);

    typedef enum logic [1:0] {SEARCH, ACQ, LOCKED} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_match, w_match_nxt;
    logic [PW-1:0]      r_phase, w_phase_nxt;
    logic [PW-1:0]      w_dec, w_exp;
    logic [OW-1:0]      w_ones;
    logic [size-1:0]    w_diff;
    logic               w_legal, w_inseq, w_wrap;
    logic               w_rev, w_ec, w_es;
    logic               r_rev, r_ec, r_es, r_sticky;
    logic [CNT_W-1:0]   r_rev_cnt;

    // A legal Johnson word has at most one boundary between adjacent bits.
    always_comb begin
        w_diff = '0;
        for (int i = 0; i < size; i++)
            w_diff[i] = bus.jc_in[i] ^ bus.jc_in[i+1];
    end

    assign w_legal = ($countones(w_diff) <= 1);
    assign w_ones  = OW'($countones(bus.jc_in));

    always_comb begin
        w_dec = '0;
        if (bus.jc_in[0])
            w_dec = PW'(w_ones);
        else if (w_ones != '0)
            w_dec = PW'(M - int'(w_ones));
    end

    assign w_exp   = (r_phase == PW'(M - 1)) ? '0 : r_phase + 1'b1;
    assign w_inseq = (w_dec == w_exp);
    assign w_wrap  = (r_phase == PW'(M - 1)) && (w_dec == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_phase_nxt = r_phase;
        w_rev       = 1'b0;
        w_ec        = 1'b0;
        w_es        = 1'b0;
        if (bus.in_valid) begin
            if (!w_legal) begin
                w_ec        = 1'b1;
                w_state_nxt = SEARCH;
                w_match_nxt = '0;
            end else begin
                w_phase_nxt = w_dec;
                unique case (r_state)
                    SEARCH: begin
                        w_state_nxt = ACQ;
                        w_match_nxt = 4'd1;
                    end
                    ACQ: begin
                        if (w_inseq) begin
                            w_match_nxt = r_match + 4'd1;
                            if (r_match + 4'd1 == 4'(LOCK_N))
                                w_state_nxt = LOCKED;
                        end else begin
                            w_match_nxt = 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (w_inseq) begin
                            w_rev = w_wrap;
                        end else begin
                            w_es        = 1'b1;
                            w_state_nxt = SEARCH;
                            w_match_nxt = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = SEARCH;
                        w_match_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_state   <= SEARCH;
            r_match   <= '0;
            r_phase   <= '0;
            r_rev     <= 1'b0;
            r_rev_cnt <= '0;
            r_ec      <= 1'b0;
            r_es      <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_match   <= w_match_nxt;
            r_phase   <= w_phase_nxt;
            r_rev     <= w_rev;
            r_rev_cnt <= r_rev_cnt + CNT_W'(w_rev);
            r_ec      <= w_ec;
            r_es      <= w_es;
            // A new error beats a clear in the same cycle.
            r_sticky  <= w_ec | w_es | (r_sticky & ~bus.clr_err);
        end
    end

    assign bus.phase      = r_phase;
    assign bus.locked     = (r_state == LOCKED);
    assign bus.rev_pulse  = r_rev;
    assign bus.rev_cnt    = r_rev_cnt;
    assign bus.err_code   = r_ec;
    assign bus.err_seq    = r_es;
    assign bus.err_sticky = r_sticky;
endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Directed bench for johnson_phase_tracker: lock, revolutions, errors,
// gaps, reset and sticky-clear precedence.
module tb_johnson_phase_tracker;
    localparam int SIZE   = 7;
    localparam int LOCK_N = 4;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic r;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    johnson_phase_tracker_if #(.size(SIZE), .CNT_W(CNT_W)) bus ();

    johnson_phase_tracker #(
        .size(SIZE), .LOCK_N(LOCK_N), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .r(r),
        .bus(bus)
    );

    // Johnson word for phase p: p ones shifted in, then p-8 zeros.
    function automatic logic [0:7] jcode(input int p);
        logic [0:7] c;
        for (int i = 0; i < 8; i++)
            c[i] = (p <= 8) ? (i < p) : (i >= p - 8);
        return c;
    endfunction

    task automatic step(input logic [0:7] code, input logic v,
                        input logic clr, input logic rst);
        @(negedge clk);
        bus.jc_in    = code;
        bus.in_valid = v;
        bus.clr_err  = clr;
        r            = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.jc_in = '0; bus.in_valid = 1'b0; bus.clr_err = 1'b0; r = 1'b1;
        step(jcode(6), 1'b1, 1'b0, 1'b1);
        checks++;
        if ({bus.phase, bus.locked, bus.rev_pulse, bus.err_code,
             bus.err_seq, bus.err_sticky} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outs: got ph=%0d lk=%0b rp=%0b ec=%0b es=%0b st=%0b want all 0",
                     bus.phase, bus.locked, bus.rev_pulse, bus.err_code,
                     bus.err_seq, bus.err_sticky);
        end
        checks++;
        if (bus.rev_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_revcnt: got %0d want 0", bus.rev_cnt);
        end
    endtask

    task automatic test_acquire();
        for (int p = 0; p < 4; p++) begin
            step(jcode(p), 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.locked !== (p == 3)) begin
                errors++;
                $display("FAIL acq_locked[%0d]: got %0b want %0b", p, bus.locked, p == 3);
            end
        end
        checks++;
        if (bus.phase !== 4'd3 || bus.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL acq_state: got ph=%0d st=%0b want ph=3 st=0",
                     bus.phase, bus.err_sticky);
        end
    endtask

    task automatic test_revolution();
        for (int k = 4; k < 20; k++) begin
            step(jcode(k % 16), 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.rev_pulse !== ((k % 16) == 0) || bus.phase !== 4'(k % 16)) begin
                errors++;
                $display("FAIL rev_step[%0d]: got rp=%0b ph=%0d want rp=%0b ph=%0d",
                         k, bus.rev_pulse, bus.phase, (k % 16) == 0, k % 16);
            end
        end
        checks++;
        if (bus.rev_cnt !== 8'd1 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL rev_cnt1: got cnt=%0d lk=%0b want cnt=1 lk=1",
                     bus.rev_cnt, bus.locked);
        end
    endtask

    task automatic test_rev_wrap();
        int pulses = 0;
        int bad = 0;
        for (int k = 4; k < 4 + 255 * 16; k++) begin
            step(jcode(k % 16), 1'b1, 1'b0, 1'b0);
            pulses += int'(bus.rev_pulse);
            bad    += int'(bus.err_code | bus.err_seq);
        end
        checks++;
        if (pulses != 255 || bad != 0) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d pulses %0d errs want 255 pulses 0 errs",
                     pulses, bad);
        end
        checks++;
        if (bus.rev_cnt !== 8'd0 || bus.phase !== 4'd3 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL wrap_cnt: got cnt=%0d ph=%0d lk=%0b want cnt=0 ph=3 lk=1",
                     bus.rev_cnt, bus.phase, bus.locked);
        end
    endtask

    task automatic test_gaps();
        for (int k = 0; k < 3; k++) begin
            step(8'b10100000, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.locked !== 1'b1 || bus.phase !== 4'd3 || bus.err_code !== 1'b0
                || bus.err_sticky !== 1'b0 || bus.rev_pulse !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold[%0d]: got lk=%0b ph=%0d ec=%0b st=%0b rp=%0b want 1 3 0 0 0",
                         k, bus.locked, bus.phase, bus.err_code, bus.err_sticky, bus.rev_pulse);
            end
        end
        step(jcode(4), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.phase !== 4'd4) begin
            errors++;
            $display("FAIL gap_resume: got lk=%0b ph=%0d want lk=1 ph=4", bus.locked, bus.phase);
        end
    endtask

    task automatic test_illegal();
        step(jcode(5), 1'b1, 1'b0, 1'b0);
        step(8'b10100000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.err_code !== 1'b1 || bus.err_sticky !== 1'b1 || bus.locked !== 1'b0
            || bus.phase !== 4'd5 || bus.err_seq !== 1'b0) begin
            errors++;
            $display("FAIL illegal: got ec=%0b st=%0b lk=%0b ph=%0d es=%0b want 1 1 0 5 0",
                     bus.err_code, bus.err_sticky, bus.locked, bus.phase, bus.err_seq);
        end
        step(8'b10100000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.err_code !== 1'b0 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL illegal_pulse: got ec=%0b st=%0b want ec=0 st=1",
                     bus.err_code, bus.err_sticky);
        end
        for (int p = 2; p < 6; p++) begin
            step(jcode(p), 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.locked !== (p == 5)) begin
                errors++;
                $display("FAIL relock[%0d]: got %0b want %0b", p, bus.locked, p == 5);
            end
        end
    endtask

    task automatic test_seq_skip();
        step(8'b11111110, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.err_seq !== 1'b1 || bus.locked !== 1'b0 || bus.phase !== 4'd7
            || bus.err_code !== 1'b0) begin
            errors++;
            $display("FAIL seq_skip: got es=%0b lk=%0b ph=%0d ec=%0b want 1 0 7 0",
                     bus.err_seq, bus.locked, bus.phase, bus.err_code);
        end
        step(jcode(8), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.err_seq !== 1'b0 || bus.phase !== 4'd8) begin
            errors++;
            $display("FAIL seq_pulse: got es=%0b ph=%0d want es=0 ph=8", bus.err_seq, bus.phase);
        end
    endtask

    task automatic test_repeat();
        for (int p = 9; p < 12; p++) step(jcode(p), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL rep_lock: got %0b want 1", bus.locked);
        end
        step(jcode(11), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.err_seq !== 1'b1 || bus.locked !== 1'b0 || bus.phase !== 4'd11) begin
            errors++;
            $display("FAIL repeat: got es=%0b lk=%0b ph=%0d want 1 0 11",
                     bus.err_seq, bus.locked, bus.phase);
        end
    endtask

    task automatic test_acq_restart();
        logic [3:0] ph [6] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd8};
        for (int k = 0; k < 6; k++) begin
            step(jcode(int'(ph[k])), 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.locked !== (k == 5) || bus.err_seq !== 1'b0 || bus.err_code !== 1'b0) begin
                errors++;
                $display("FAIL acq_restart[%0d]: got lk=%0b es=%0b ec=%0b want lk=%0b es=0 ec=0",
                         k, bus.locked, bus.err_seq, bus.err_code, k == 5);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        for (int k = 9; k <= 48; k++) step(jcode(k % 16), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.rev_cnt !== 8'd3 || bus.locked !== 1'b1 || bus.phase !== 4'd0) begin
            errors++;
            $display("FAIL pre_reset: got cnt=%0d lk=%0b ph=%0d want 3 1 0",
                     bus.rev_cnt, bus.locked, bus.phase);
        end
        step(jcode(1), 1'b1, 1'b0, 1'b1);
        checks++;
        if ({bus.phase, bus.locked, bus.rev_pulse, bus.err_code, bus.err_seq,
             bus.err_sticky} !== 9'd0 || bus.rev_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got ph=%0d lk=%0b cnt=%0d st=%0b want all 0",
                     bus.phase, bus.locked, bus.rev_cnt, bus.err_sticky);
        end
        for (int p = 1; p < 5; p++) begin
            step(jcode(p), 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.locked !== (p == 4)) begin
                errors++;
                $display("FAIL post_reset_acq[%0d]: got %0b want %0b", p, bus.locked, p == 4);
            end
        end
    endtask

    task automatic test_clr_precedence();
        step(8'b10100000, 1'b1, 1'b0, 1'b0);
        step(8'b10100000, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.err_sticky !== 1'b1 || bus.err_code !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set: got st=%0b ec=%0b want st=1 ec=1",
                     bus.err_sticky, bus.err_code);
        end
        step(8'b10100000, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.err_sticky !== 1'b0 || bus.err_code !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone: got st=%0b ec=%0b want st=0 ec=0",
                     bus.err_sticky, bus.err_code);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_revolution();
        test_rev_wrap();
        test_gaps();
        test_illegal();
        test_seq_skip();
        test_repeat();
        test_acq_restart();
        test_reset_mid_lock();
        test_clr_precedence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
